// File: rtl/gf180mcu_ht_io__dom_seq.sv
// Pad-ring power-domain enable sequencer: debounces per-segment power-good, ramps
// segment pad drivers up one at a time, tears them down in reverse, isolates on loss.
module gf180mcu_ht_io__dom_seq #(
    parameter int NSEG   = 4,
    parameter int DEB    = 8,
    parameter int SETTLE = 16
) (
    input  logic            CLK,
    input  logic            RN,
    input  logic            EN,
    input  logic [NSEG-1:0] PG,
    input  logic            CLR_FAULT,
    output logic [NSEG-1:0] SEG_EN,
    output logic            ISO,
    output logic            READY,
    output logic            FAULT,
    output logic [2:0]      FAULT_SEG
);

    typedef enum logic [2:0] {
        S_OFF,
        S_WAIT_PG,
        S_RAMP,
        S_RUN,
        S_SHUTDOWN,
        S_FAULT
    } state_t;

    localparam logic [7:0]      DEB_FULL    = 8'(DEB);
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [2:0]      LAST_IDX    = 3'(NSEG - 1);
    localparam logic [NSEG-1:0] SEG_ONE     = {{(NSEG-1){1'b0}}, 1'b1};

    logic [NSEG-1:0] sync_a;
    logic [NSEG-1:0] ps;
    logic [7:0]      deb_cnt [NSEG];
    logic [NSEG-1:0] pg_ok;

    state_t          state, state_n;
    logic [2:0]      idx, idx_n;
    logic [7:0]      settle_cnt, settle_n;
    logic [NSEG-1:0] seg_en_r, seg_en_n;
    logic            iso_r, iso_n;
    logic            ready_r, ready_n;
    logic            fault_r, fault_n;
    logic [2:0]      fault_seg_r, fault_seg_n;

    logic            pg_lost;
    logic            settle_done;
    logic [2:0]      lost_idx;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sync_a <= '0;
            ps     <= '0;
        end else begin
            sync_a <= PG;
            ps     <= sync_a;
        end
    end

    // Acceptance is slow (saturating count), loss is immediate (ps gates pg_ok).
    for (genvar i = 0; i < NSEG; i++) begin : g_deb
        always_ff @(posedge CLK or negedge RN) begin
            if (!RN) begin
                deb_cnt[i] <= '0;
            end else if (!ps[i]) begin
                deb_cnt[i] <= '0;
            end else if (deb_cnt[i] != DEB_FULL) begin
                deb_cnt[i] <= deb_cnt[i] + 8'd1;
            end
        end
        assign pg_ok[i] = ps[i] && (deb_cnt[i] == DEB_FULL);
    end

    always_comb begin
        lost_idx = 3'd0;
        for (int i = NSEG - 1; i >= 0; i--) begin
            if (!pg_ok[i]) begin
                lost_idx = 3'(i);
            end
        end
    end

    assign pg_lost     = ~&pg_ok;
    assign settle_done = (settle_cnt == SETTLE_LAST);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state       <= S_OFF;
            idx         <= '0;
            settle_cnt  <= '0;
            seg_en_r    <= '0;
            iso_r       <= 1'b1;
            ready_r     <= 1'b0;
            fault_r     <= 1'b0;
            fault_seg_r <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            settle_cnt  <= settle_n;
            seg_en_r    <= seg_en_n;
            iso_r       <= iso_n;
            ready_r     <= ready_n;
            fault_r     <= fault_n;
            fault_seg_r <= fault_seg_n;
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        settle_n    = settle_cnt;
        seg_en_n    = seg_en_r;
        iso_n       = iso_r;
        ready_n     = ready_r;
        fault_n     = fault_r;
        fault_seg_n = fault_seg_r;

        case (state)
            S_OFF: begin
                seg_en_n = '0;
                iso_n    = 1'b1;
                ready_n  = 1'b0;
                idx_n    = '0;
                settle_n = '0;
                if (EN) begin
                    state_n = S_WAIT_PG;
                end
            end

            S_WAIT_PG: begin
                if (!EN) begin
                    state_n = S_OFF;
                end else if (&pg_ok) begin
                    state_n  = S_RAMP;
                    idx_n    = '0;
                    settle_n = '0;
                    seg_en_n = SEG_ONE;
                end
            end

            S_RAMP: begin
                if (pg_lost) begin
                    state_n     = S_FAULT;
                    seg_en_n    = '0;
                    iso_n       = 1'b1;
                    ready_n     = 1'b0;
                    fault_n     = 1'b1;
                    fault_seg_n = lost_idx;
                end else if (!EN) begin
                    // idx already names the highest enabled segment
                    state_n  = S_SHUTDOWN;
                    settle_n = '0;
                    iso_n    = 1'b1;
                    ready_n  = 1'b0;
                end else if (settle_done) begin
                    settle_n = '0;
                    if (idx == LAST_IDX) begin
                        state_n = S_RUN;
                        iso_n   = 1'b0;
                        ready_n = 1'b1;
                    end else begin
                        idx_n    = idx + 3'd1;
                        seg_en_n = seg_en_r | (SEG_ONE << idx_n);
                    end
                end else begin
                    settle_n = settle_cnt + 8'd1;
                end
            end

            S_RUN: begin
                if (pg_lost) begin
                    state_n     = S_FAULT;
                    seg_en_n    = '0;
                    iso_n       = 1'b1;
                    ready_n     = 1'b0;
                    fault_n     = 1'b1;
                    fault_seg_n = lost_idx;
                end else if (!EN) begin
                    state_n  = S_SHUTDOWN;
                    idx_n    = LAST_IDX;
                    settle_n = '0;
                    iso_n    = 1'b1;
                    ready_n  = 1'b0;
                end
            end

            S_SHUTDOWN: begin
                if (settle_done) begin
                    settle_n = '0;
                    seg_en_n = seg_en_r & ~(SEG_ONE << idx);
                    if (idx == 3'd0) begin
                        state_n = S_OFF;
                    end else begin
                        idx_n = idx - 3'd1;
                    end
                end else begin
                    settle_n = settle_cnt + 8'd1;
                end
            end

            S_FAULT: begin
                if (CLR_FAULT && !EN) begin
                    state_n     = S_OFF;
                    fault_n     = 1'b0;
                    fault_seg_n = '0;
                end
            end

            default: begin
                state_n = S_OFF;
            end
        endcase
    end

    assign SEG_EN    = seg_en_r;
    assign ISO       = iso_r;
    assign READY     = ready_r;
    assign FAULT     = fault_r;
    assign FAULT_SEG = fault_seg_r;

endmodule

// File: tb/tb_gf180mcu_ht_io__dom_seq.sv
// Bench for the pad-ring domain sequencer: a timestamp-based behavioural model is
// compared against the outputs every cycle, plus directed literal checks.
module tb_gf180mcu_ht_io__dom_seq;

    localparam int NSEG   = 4;
    localparam int DEB    = 4;
    localparam int SETTLE = 3;

    localparam int M_OFF  = 0;
    localparam int M_WAIT = 1;
    localparam int M_RAMP = 2;
    localparam int M_RUN  = 3;
    localparam int M_SHUT = 4;
    localparam int M_FLT  = 5;

    logic            CLK = 1'b0;
    logic            RN = 1'b1;
    logic            EN = 1'b0;
    logic [NSEG-1:0] PG = '0;
    logic            CLR_FAULT = 1'b0;
    logic [NSEG-1:0] SEG_EN;
    logic            ISO;
    logic            READY;
    logic            FAULT;
    logic [2:0]      FAULT_SEG;

    int checks = 0;
    int errors = 0;

    // Model: mode plus edge timestamps of ramp start / shutdown start.
    int              m_mode, m_n, m_t0, m_sd0, m_h, m_fseg;
    int              m_run [NSEG];
    logic [NSEG-1:0] m_ok;

    gf180mcu_ht_io__dom_seq #(.NSEG(NSEG), .DEB(DEB), .SETTLE(SETTLE)) dut (
        .CLK(CLK), .RN(RN), .EN(EN), .PG(PG), .CLR_FAULT(CLR_FAULT),
        .SEG_EN(SEG_EN), .ISO(ISO), .READY(READY), .FAULT(FAULT), .FAULT_SEG(FAULT_SEG)
    );

    initial forever #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic model_reset();
        m_mode = M_OFF;
        m_n    = 0;
        m_t0   = 0;
        m_sd0  = 0;
        m_h    = 0;
        m_fseg = 0;
        m_ok   = '0;
        foreach (m_run[i]) m_run[i] = 0;
    endtask

    // pg_ok after edge n means PG was sampled high on the DEB+1 edges ending at n-1.
    task automatic model_step();
        int low;
        low = 0;
        m_n++;
        for (int i = NSEG - 1; i >= 0; i--) if (!m_ok[i]) low = i;
        case (m_mode)
            M_OFF:  if (EN) m_mode = M_WAIT;
            M_WAIT: begin
                if (!EN) m_mode = M_OFF;
                else if (&m_ok) begin m_mode = M_RAMP; m_t0 = m_n; end
            end
            M_RAMP: begin
                if (!(&m_ok)) begin m_mode = M_FLT; m_fseg = low; end
                else if (!EN) begin
                    m_h    = (m_n - 1 - m_t0) / SETTLE;
                    m_sd0  = m_n;
                    m_mode = M_SHUT;
                end else if (m_n == m_t0 + NSEG * SETTLE) m_mode = M_RUN;
            end
            M_RUN: begin
                if (!(&m_ok)) begin m_mode = M_FLT; m_fseg = low; end
                else if (!EN) begin m_h = NSEG - 1; m_sd0 = m_n; m_mode = M_SHUT; end
            end
            M_SHUT: if (m_n == m_sd0 + (m_h + 1) * SETTLE) m_mode = M_OFF;
            M_FLT:  if (CLR_FAULT && !EN) m_mode = M_OFF;
            default: m_mode = M_OFF;
        endcase
        for (int i = 0; i < NSEG; i++) begin
            m_ok[i]  = (m_run[i] >= DEB + 1);
            m_run[i] = PG[i] ? ((m_run[i] < 1000) ? m_run[i] + 1 : m_run[i]) : 0;
        end
    endtask

    function automatic logic [NSEG+5:0] model_out();
        logic [NSEG-1:0] seg;
        logic [2:0]      fs;
        seg = '0;
        if (m_mode == M_RAMP) begin
            for (int j = 0; j < NSEG; j++) if (m_t0 + j * SETTLE <= m_n) seg[j] = 1'b1;
        end else if (m_mode == M_RUN) begin
            seg = '1;
        end else if (m_mode == M_SHUT) begin
            for (int j = 0; j <= m_h; j++)
                if (m_n < m_sd0 + (m_h - j + 1) * SETTLE) seg[j] = 1'b1;
        end
        fs = (m_mode == M_FLT) ? 3'(m_fseg) : 3'd0;
        return {seg, (m_mode != M_RUN), (m_mode == M_RUN), (m_mode == M_FLT), fs};
    endfunction

    task automatic check_output();
        logic [NSEG+5:0] act, exp;
        act = {SEG_EN, ISO, READY, FAULT, FAULT_SEG};
        exp = model_out();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL model t=%0t actual{seg,iso,rdy,flt,fseg}=%b required=%b",
                     $time, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RN) model_step();
        @(negedge CLK);
        check_output();
    endtask

    task automatic apply_stimulus(input logic en, input logic [NSEG-1:0] pg, input logic clr);
        EN        = en;
        PG        = pg;
        CLR_FAULT = clr;
    endtask

    task automatic wait_seg(input string name, input logic [NSEG-1:0] target, input int budget);
        int k;
        k = 0;
        while (SEG_EN !== target && k < budget) begin
            tick();
            k++;
        end
        check_val(name, 32'(SEG_EN), 32'(target));
    endtask

    initial begin
        logic [NSEG-1:0] pg_v;
        logic            en_v;

        model_reset();
        apply_stimulus(1'b0, '0, 1'b0);
        #1 RN = 1'b0;
        #11;
        check_val("rst_seg_en", 32'(SEG_EN), 32'h0);
        check_val("rst_iso", 32'(ISO), 32'h1);
        check_val("rst_ready", 32'(READY), 32'h0);
        check_val("rst_fault", 32'(FAULT), 32'h0);
        check_val("rst_fault_seg", 32'(FAULT_SEG), 32'h0);
        tick();
        tick();

        // Power-up from reset release.
        RN = 1'b1;
        apply_stimulus(1'b1, 4'hF, 1'b0);
        repeat (6) tick();
        check_val("pu_e5", 32'(SEG_EN), 32'h0);
        tick();
        check_val("pu_e6", 32'(SEG_EN), 32'h1);
        repeat (SETTLE) tick();
        check_val("pu_e9", 32'(SEG_EN), 32'h3);
        repeat (SETTLE) tick();
        check_val("pu_e12", 32'(SEG_EN), 32'h7);
        repeat (SETTLE) tick();
        check_val("pu_e15", 32'(SEG_EN), 32'hF);
        repeat (SETTLE - 1) tick();
        check_val("pu_e17_iso", 32'(ISO), 32'h1);
        tick();
        check_val("pu_e18_iso", 32'(ISO), 32'h0);
        check_val("pu_e18_ready", 32'(READY), 32'h1);

        // Orderly shutdown.
        apply_stimulus(1'b0, 4'hF, 1'b0);
        tick();
        check_val("sd_m_iso", 32'(ISO), 32'h1);
        check_val("sd_m_ready", 32'(READY), 32'h0);
        check_val("sd_m_seg", 32'(SEG_EN), 32'hF);
        repeat (SETTLE) tick();
        check_val("sd_m3", 32'(SEG_EN), 32'h7);
        repeat (SETTLE) tick();
        check_val("sd_m6", 32'(SEG_EN), 32'h3);
        repeat (SETTLE) tick();
        check_val("sd_m9", 32'(SEG_EN), 32'h1);
        repeat (SETTLE) tick();
        check_val("sd_m12", 32'(SEG_EN), 32'h0);
        tick();

        // Glitch on PG[2] during WAIT_PG restarts debounce.
        apply_stimulus(1'b0, 4'h0, 1'b0);
        repeat (3) tick();
        apply_stimulus(1'b1, 4'hF, 1'b0);
        repeat (2) tick();
        apply_stimulus(1'b1, 4'b1011, 1'b0);
        repeat (2) tick();
        apply_stimulus(1'b1, 4'hF, 1'b0);
        repeat (6) tick();
        check_val("gl_e9", 32'(SEG_EN), 32'h0);
        tick();
        check_val("gl_e10", 32'(SEG_EN), 32'h1);
        check_val("gl_fault", 32'(FAULT), 32'h0);
        wait_seg("gl_full", 4'hF, 40);
        repeat (SETTLE) tick();
        check_val("gl_ready", 32'(READY), 32'h1);

        // Supply loss in RUN on segments 1 and 3.
        apply_stimulus(1'b1, 4'b0101, 1'b0);
        repeat (2) tick();
        check_val("sl_k1_seg", 32'(SEG_EN), 32'hF);
        tick();
        check_val("sl_k2_seg", 32'(SEG_EN), 32'h0);
        check_val("sl_k2_iso", 32'(ISO), 32'h1);
        check_val("sl_k2_fault", 32'(FAULT), 32'h1);
        check_val("sl_k2_fseg", 32'(FAULT_SEG), 32'h1);
        apply_stimulus(1'b1, 4'hF, 1'b1);
        repeat (2) tick();
        check_val("sl_clr_en1", 32'(FAULT), 32'h1);
        check_val("sl_clr_en1_fseg", 32'(FAULT_SEG), 32'h1);
        apply_stimulus(1'b0, 4'hF, 1'b1);
        tick();
        check_val("sl_clr_fault", 32'(FAULT), 32'h0);
        check_val("sl_clr_fseg", 32'(FAULT_SEG), 32'h0);
        apply_stimulus(1'b0, 4'hF, 1'b0);
        tick();

        // EN drop mid-ramp walks down only segments 1 and 0.
        apply_stimulus(1'b1, 4'hF, 1'b0);
        wait_seg("mr_reach", 4'h3, 40);
        apply_stimulus(1'b0, 4'hF, 1'b0);
        tick();
        check_val("mr_m_seg", 32'(SEG_EN), 32'h3);
        check_val("mr_m_iso", 32'(ISO), 32'h1);
        repeat (SETTLE) tick();
        check_val("mr_m3", 32'(SEG_EN), 32'h1);
        repeat (SETTLE) tick();
        check_val("mr_m6", 32'(SEG_EN), 32'h0);
        tick();

        // Asynchronous reset mid-ramp.
        apply_stimulus(1'b1, 4'hF, 1'b0);
        wait_seg("ar_reach", 4'h7, 60);
        #2 RN = 1'b0;
        #1;
        check_val("ar_seg", 32'(SEG_EN), 32'h0);
        check_val("ar_iso", 32'(ISO), 32'h1);
        model_reset();
        repeat (2) tick();
        RN = 1'b1;
        repeat (6) tick();
        check_val("ar_restart_e5", 32'(SEG_EN), 32'h0);
        tick();
        check_val("ar_restart_e6", 32'(SEG_EN), 32'h1);

        // Randomized traffic against the model.
        pg_v = 4'hF;
        en_v = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NSEG; i++) begin
                if (!pg_v[i]) begin
                    if ($urandom_range(0, 3) == 0) pg_v[i] = 1'b1;
                end else if ($urandom_range(0, 249) == 0) begin
                    pg_v[i] = 1'b0;
                end
            end
            if ($urandom_range(0, 39) == 0) en_v = ~en_v;
            apply_stimulus(en_v, pg_v, ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 499) == 0) begin
                RN = 1'b0;
                model_reset();
                tick();
                RN = 1'b1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
